gp_deserializer: RTL
====================

Name: gp_deserializer

Overview:
Downstream stage of the grasspopper encoder. Consumes the encoder's 1-bit serial ciphertext stream, qualified by its busy output, and reassembles 128-bit blocks. Completed blocks go into a 2-entry buffer and are presented on a valid/ready interface to the consumer (bus wrapper / result register). Sticky flags report framing and overrun errors.

Parameters:
BLOCK_W, 128, bits per reassembled block; the bit counter width is $clog2(BLOCK_W).
FIFO_DEPTH, 2, output buffer entries; fixed at 2 in this revision.

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
ser_i  input  1  serial ciphertext bit; connects to encoder data_o
busy_i  input  1  encoder busy; ser_i is valid on every rising edge where busy_i=1
clear_i  input  1  synchronous clear of sticky error flags
block_o  output  BLOCK_W  head-of-buffer block; bit 127 is the first serial bit received
valid_o  output  1  buffer non-empty
ready_i  input  1  consumer accepts block_o when valid_o & ready_i
short_o  output  1  sticky; busy_i fell with a partial block in progress
overrun_o  output  1  sticky; a block completed while the buffer was full and was dropped
bit_cnt_o  output  7  current bit count in the block being assembled (debug)

Behaviour:
- Reset (asynchronous): shift register=0, bit_cnt=0, FSM=IDLE, buffer empty, valid_o=0, block_o=0, short_o=0, overrun_o=0.
- FSM states IDLE and SHIFT.
  - IDLE -> SHIFT on an edge with busy_i=1; that edge samples bit 0.
  - SHIFT stays while busy_i=1.
  - SHIFT -> IDLE on an edge with busy_i=0.
- Shift on every edge with busy_i=1: sr <= {sr[BLOCK_W-2:0], ser_i}; bit_cnt increments.
- Block completion: the edge sampling bit 127 pushes {sr[126:0], ser_i} into the buffer and wraps bit_cnt to 0 on that same edge.
  - valid_o rises the cycle after (latency 1 clock from the last bit).
  - If busy_i stays high, the next edge is bit 0 of the next block; back-to-back blocks are supported with no gap.
- busy_i low with bit_cnt!=0 (premature drop): partial data discarded, bit_cnt<=0, short_o<=1.
- busy_i low with bit_cnt==0: normal end of stream, no flag.
- Buffer is a 2-entry FIFO.
  - Pop on valid_o & ready_i; block_o shows the next entry (or holds its last value if empty) the following cycle.
  - block_o is stable while valid_o=1 and ready_i=0.
- Full buffer on push:
  - Push and pop on the same edge: both occur, no overrun.
  - Push without pop: new block dropped, contents unchanged, overrun_o<=1.
- Push and pop on an empty buffer never occur on the same edge, because valid_o=0 blocks the pop.
- Sticky flags:
  - clear_i=1 clears short_o and overrun_o on the next edge.
  - Set beats clear if both happen on the same edge.
- Reset mid-block or with the buffer full: everything is lost immediately; the next busy_i rise starts at bit 0.
- ser_i is ignored whenever busy_i=0.

Decomposition:
- Package gp_pkg: GP_BLOCK_W=128, GP_CNT_W=7, FSM state enum (GP_DS_IDLE, GP_DS_SHIFT). The encoder shares the block width and bit ordering constants.
- One sub-module, gp_block_fifo: 2-entry, BLOCK_W-wide synchronous FIFO with push/pop/full/empty and asynchronous active-high reset.
- The top level holds the FSM, shift register, counter and flag logic.

Test Plan:
1. Reset, then busy_i high 128 cycles shifting 128'h7f679d90bebc24305a468d42b9d4edcd MSB-first -> valid_o=1 exactly 1 cycle after the last bit, block_o=7f679d90bebc24305a468d42b9d4edcd, no flags set.
2. Two back-to-back blocks (256 busy cycles: the vector above, then its bitwise inverse) with ready_i=0 -> both buffered. With ready_i=1 they pop in order: 7f67...edcd, then 8098...1232; valid_o then falls.
3. Three consecutive blocks with ready_i held 0 -> first two retained in order, overrun_o=1. clear_i pulse -> overrun_o=0 next cycle.
4. busy_i high for 50 cycles then low -> no valid_o, short_o=1, bit_cnt_o=0. Then a full 128-bit block -> correct block_o, short_o stays 1 until clear_i.
5. Buffer full; third block completes on the same edge as a pop (ready_i=1) -> no overrun. Buffer holds blocks 2 and 3, delivered in order.
6. Assert reset at bit 64 of a block with one block already buffered -> valid_o=0 and bit_cnt_o=0 immediately (asynchronous). A subsequent full block is received correctly.

Source files
------------

// File: rtl/gp_pkg.sv
// Shared constants for the grasspopper datapath: block width, bit-counter width
// and the deserializer FSM states.
package gp_pkg;
   localparam int GP_BLOCK_W = 128;
   localparam int GP_CNT_W   = $clog2(GP_BLOCK_W);

   typedef enum logic {
      GP_DS_IDLE,
      GP_DS_SHIFT
   } gp_ds_state_e;
endpackage

// File: rtl/gp_block_fifo.sv
// Small block FIFO with a registered head output that holds its last value
// when the buffer drains.
module gp_block_fifo
   import gp_pkg::*;
#(
   parameter int BLOCK_W = GP_BLOCK_W,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [BLOCK_W-1:0] din_i,
   output logic [BLOCK_W-1:0] dout_o,
   output logic               full_o,
   output logic               empty_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [BLOCK_W-1:0] mem_q [DEPTH];
   logic [BLOCK_W-1:0] dout_q, dout_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      do_pop   = pop_i && (count_q != '0);
      do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      dout_d   = dout_q;
      // New head is the post-write contents of the slot at the next read pointer
      if (count_d != '0) begin
         if (do_push && (wr_ptr_q == rd_ptr_d)) dout_d = din_i;
         else                                   dout_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
      end
   end

   assign dout_o  = dout_q;
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
endmodule

// File: rtl/gp_deserializer.sv
// Reassembles the encoder's busy-qualified serial stream into BLOCK_W-bit blocks
// (first bit received lands in the MSB) and buffers them for a valid/ready consumer.
module gp_deserializer
   import gp_pkg::*;
#(
   parameter  int BLOCK_W    = GP_BLOCK_W,
   parameter  int FIFO_DEPTH = 2,
   localparam int CNT_W      = $clog2(BLOCK_W)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ser_i,
   input  logic               busy_i,
   input  logic               clear_i,
   output logic [BLOCK_W-1:0] block_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               short_o,
   output logic               overrun_o,
   output logic [CNT_W-1:0]   bit_cnt_o
);
   // The final bit of a block comes straight from ser_i, so only BLOCK_W-1 bits are held.
   logic [BLOCK_W-2:0] sr_q;
   logic [CNT_W-1:0]   cnt_q;
   gp_ds_state_e       state_q;
   logic               short_q, overrun_q;

   logic fifo_full, fifo_empty, pop, last_bit, short_set, overrun_set;

   assign last_bit    = busy_i && (cnt_q == CNT_W'(BLOCK_W - 1));
   assign pop         = valid_o && ready_i;
   assign short_set   = (state_q == GP_DS_SHIFT) && !busy_i && (cnt_q != '0);
   assign overrun_set = last_bit && fifo_full && !pop;

   gp_block_fifo #(
      .BLOCK_W (BLOCK_W),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (last_bit),
      .pop_i   (pop),
      .din_i   ({sr_q, ser_i}),
      .dout_o  (block_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= GP_DS_IDLE;
         sr_q      <= '0;
         cnt_q     <= '0;
         short_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         case (state_q)
            GP_DS_IDLE:  if (busy_i)  state_q <= GP_DS_SHIFT;
            GP_DS_SHIFT: if (!busy_i) state_q <= GP_DS_IDLE;
            default:                  state_q <= GP_DS_IDLE;
         endcase

         if (busy_i) begin
            sr_q  <= {sr_q[BLOCK_W-3:0], ser_i};
            cnt_q <= last_bit ? '0 : cnt_q + CNT_W'(1);
         end else begin
            cnt_q <= '0;
         end

         if (short_set)    short_q <= 1'b1;
         else if (clear_i) short_q <= 1'b0;

         if (overrun_set)  overrun_q <= 1'b1;
         else if (clear_i) overrun_q <= 1'b0;
      end
   end

   assign valid_o   = !fifo_empty;
   assign short_o   = short_q;
   assign overrun_o = overrun_q;
   assign bit_cnt_o = cnt_q;
endmodule
